// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - ATM PIN controller state codes and 7-segment encoding
package atm_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_CASH    = 3'd3,
        S_EJECT   = 3'd4,
        S_DESTROY = 3'd5,
        S_LOCKED  = 3'd6
    } atm_state_t;

    // Segments {g,f,e,d,c,b,a}, active-high; shows the state code as a decimal digit
    function automatic logic [6:0] seg7_encode(input atm_state_t s);
        case (s)
            S_IDLE:    return 7'b0111111;
            S_ENTRY:   return 7'b0000110;
            S_CHECK:   return 7'b1011011;
            S_CASH:    return 7'b1001111;
            S_EJECT:   return 7'b1100110;
            S_DESTROY: return 7'b1101101;
            S_LOCKED:  return 7'b1111101;
            default:   return 7'b1000000;
        endcase
    endfunction

endpackage

// File: rtl/atm_timeout.sv
// rtl/atm_timeout.sv - inter-digit idle counter, expires after TIMEOUT idle cycles
module atm_timeout #(
    parameter int TIMEOUT = 8
) (
    input  logic clk_2,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Saturates at LAST so expired stays asserted until the next load
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (tick && count != LAST) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/pin_atm_ctrl.sv
// rtl/pin_atm_ctrl.sv - ATM card PIN check FSM with retry limit and card destruction
module pin_atm_ctrl
    import atm_pkg::*;
#(
    parameter int PIN_LEN   = 3,
    parameter int DIGIT_W   = 3,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 8
) (
    input  logic                           clk_2,
    input  logic                           reset,
    input  logic                           card,
    input  logic [DIGIT_W-1:0]             digit,
    input  logic                           digit_valid,
    input  logic [PIN_LEN*DIGIT_W-1:0]     pin_code,
    output logic                           cash,
    output logic                           destroy,
    output logic                           eject,
    output logic                           locked,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
    output logic [2:0]                     state_o
);

    localparam int IW = $clog2(PIN_LEN + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] TRIES_INIT = TW'(MAX_TRIES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(PIN_LEN - 1);

    if (PIN_LEN < 1 || MAX_TRIES < 1 || TIMEOUT < 2) begin : g_param_check
        $error("pin_atm_ctrl: PIN_LEN>=1, MAX_TRIES>=1 and TIMEOUT>=2 required");
    end

    atm_state_t         state;
    logic [IW-1:0]      idx;
    logic               mismatch;
    logic [DIGIT_W-1:0] exp_digit;
    logic               t_load;
    logic               t_tick;
    logic               t_expired;

    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < PIN_LEN; i++) begin
            if (idx == IW'(i)) exp_digit = pin_code[i*DIGIT_W +: DIGIT_W];
        end
    end

    // Timer is held clear outside ENTRY, so every way into ENTRY starts a fresh window
    assign t_load = (state != S_ENTRY) || digit_valid;
    assign t_tick = (state == S_ENTRY);

    atm_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_2   (clk_2),
        .reset   (reset),
        .load    (t_load),
        .tick    (t_tick),
        .expired (t_expired)
    );

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            mismatch   <= 1'b0;
            tries_left <= TRIES_INIT;
            cash       <= 1'b0;
            destroy    <= 1'b0;
            eject      <= 1'b0;
            locked     <= 1'b0;
        end else begin
            cash    <= 1'b0;
            destroy <= 1'b0;
            eject   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (card) begin
                        state    <= S_ENTRY;
                        idx      <= '0;
                        mismatch <= 1'b0;
                    end
                end
                S_ENTRY: begin
                    if (!card) begin
                        state <= S_IDLE;
                    end else if (digit_valid) begin
                        mismatch <= mismatch | (digit != exp_digit);
                        idx      <= idx + IW'(1);
                        if (idx == IDX_LAST) state <= S_CHECK;
                    end else if (t_expired) begin
                        mismatch <= 1'b1;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!card) begin
                        state <= S_IDLE;
                    end else if (!mismatch) begin
                        state      <= S_CASH;
                        cash       <= 1'b1;
                        tries_left <= TRIES_INIT;
                    end else begin
                        tries_left <= tries_left - TW'(1);
                        idx        <= '0;
                        mismatch   <= 1'b0;
                        if (tries_left == TW'(1)) begin
                            state   <= S_DESTROY;
                            destroy <= 1'b1;
                        end else begin
                            state <= S_ENTRY;
                        end
                    end
                end
                S_CASH: begin
                    state <= S_EJECT;
                    eject <= 1'b1;
                end
                S_EJECT: begin
                    state <= S_IDLE;
                end
                S_DESTROY: begin
                    state  <= S_LOCKED;
                    locked <= 1'b1;
                end
                S_LOCKED: begin
                    locked <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pin_atm_ctrl.sv
// tb/tb_pin_atm_ctrl.sv - directed vector bench for pin_atm_ctrl
module tb_pin_atm_ctrl;

    logic        clk_2 = 1'b0;
    logic        reset = 1'b1;

    logic        card1, dv1;
    logic [2:0]  digit1;
    logic [8:0]  pin1;
    logic        cash1, destroy1, eject1, locked1;
    logic [1:0]  tries1;
    logic [2:0]  st1;

    logic        card2, dv2;
    logic [3:0]  digit2;
    logic [15:0] pin2;
    logic        cash2, destroy2, eject2, locked2;
    logic [1:0]  tries2;
    logic [2:0]  st2;

    assign pin1 = {3'd7, 3'd3, 3'd1};
    assign pin2 = {4'd9, 4'd5, 4'd2, 4'd12};

    pin_atm_ctrl dut1 (
        .clk_2(clk_2), .reset(reset), .card(card1), .digit(digit1),
        .digit_valid(dv1), .pin_code(pin1), .cash(cash1), .destroy(destroy1),
        .eject(eject1), .locked(locked1), .tries_left(tries1), .state_o(st1)
    );

    pin_atm_ctrl #(.PIN_LEN(4), .DIGIT_W(4), .MAX_TRIES(2), .TIMEOUT(8)) dut2 (
        .clk_2(clk_2), .reset(reset), .card(card2), .digit(digit2),
        .digit_valid(dv2), .pin_code(pin2), .cash(cash2), .destroy(destroy2),
        .eject(eject2), .locked(locked2), .tries_left(tries2), .state_o(st2)
    );

    always #5 clk_2 = ~clk_2;

    typedef struct {
        bit         sel;
        bit         card;
        bit         dv;
        logic [3:0] digit;
        logic [2:0] st;
        bit         c, e, d, l;
        logic [1:0] t;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   cur_sel = 1'b0;

    task automatic add(input bit card, input bit dv, input logic [3:0] digit,
                       input logic [2:0] st, input bit c, input bit e, input bit d,
                       input bit l, input logic [1:0] t);
        vec_t v;
        v.sel = cur_sel; v.card = card; v.dv = dv; v.digit = digit;
        v.st = st; v.c = c; v.e = e; v.d = d; v.l = l; v.t = t;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic check(input string name, input bit sel, input logic [2:0] st,
                         input bit c, input bit e, input bit d, input bit l,
                         input logic [1:0] t);
        logic [2:0] a_st;
        logic       a_c, a_e, a_d, a_l;
        logic [1:0] a_t;
        if (sel) begin
            a_st = st2; a_c = cash2; a_e = eject2; a_d = destroy2; a_l = locked2; a_t = tries2;
        end else begin
            a_st = st1; a_c = cash1; a_e = eject1; a_d = destroy1; a_l = locked1; a_t = tries1;
        end
        n_vec++;
        if ({a_st, a_c, a_e, a_d, a_l, a_t} !== {st, c, e, d, l, t}) begin
            n_err++;
            $display("FAIL %s: got state=%0d cash=%b eject=%b destroy=%b locked=%b tries=%0d, want state=%0d cash=%b eject=%b destroy=%b locked=%b tries=%0d",
                     name, a_st, a_c, a_e, a_d, a_l, a_t, st, c, e, d, l, t);
        end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (vecs[i].sel) begin
                card2 = vecs[i].card; dv2 = vecs[i].dv; digit2 = vecs[i].digit;
                card1 = 1'b0; dv1 = 1'b0;
            end else begin
                card1 = vecs[i].card; dv1 = vecs[i].dv; digit1 = vecs[i].digit[2:0];
                card2 = 1'b0; dv2 = 1'b0;
            end
            step();
            check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].st, vecs[i].c,
                  vecs[i].e, vecs[i].d, vecs[i].l, vecs[i].t);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_hi, b_hi, c_hi;
        logic [2:0] good [3];
        good = '{3'd1, 3'd3, 3'd7};
        card1 = 0; dv1 = 0; digit1 = 0;
        card2 = 0; dv2 = 0; digit2 = 0;

        // A: stray strobe, correct code, three wrong codes to lock
        cur_sel = 1'b0;
        add(0, 1, 1, 0, 0, 0, 0, 0, 3);
        add(1, 0, 0, 1, 0, 0, 0, 0, 3);
        add(1, 1, 1, 1, 0, 0, 0, 0, 3);
        add(1, 0, 0, 1, 0, 0, 0, 0, 3);
        add(1, 1, 3, 1, 0, 0, 0, 0, 3);
        add(1, 0, 0, 1, 0, 0, 0, 0, 3);
        add(1, 1, 7, 2, 0, 0, 0, 0, 3);
        add(1, 0, 0, 3, 1, 0, 0, 0, 3);
        add(1, 1, 1, 4, 0, 1, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 3);
        add(1, 0, 0, 1, 0, 0, 0, 0, 3);
        for (int k = 0; k < 3; k++) begin
            add(1, 1, 1, 1, 0, 0, 0, 0, 2'(3 - k));
            add(1, 1, 3, 1, 0, 0, 0, 0, 2'(3 - k));
            add(1, 1, 6, 2, 0, 0, 0, 0, 2'(3 - k));
            if (k < 2) add(1, 0, 0, 1, 0, 0, 0, 0, 2'(2 - k));
            else       add(1, 0, 0, 5, 0, 0, 1, 0, 0);
        end
        add(1, 0, 0, 6, 0, 0, 0, 1, 0);
        add(0, 1, 5, 6, 0, 0, 0, 1, 0);
        add(1, 0, 0, 6, 0, 0, 0, 1, 0);
        a_hi = vecs.size();

        // B: timeout, card drop, strobe beating timeout
        add(1, 0, 0, 1, 0, 0, 0, 0, 3);
        add(1, 1, 1, 1, 0, 0, 0, 0, 3);
        for (int k = 0; k < 7; k++) add(1, 0, 0, 1, 0, 0, 0, 0, 3);
        add(1, 0, 0, 2, 0, 0, 0, 0, 3);
        add(1, 0, 0, 1, 0, 0, 0, 0, 2);
        add(1, 1, 1, 1, 0, 0, 0, 0, 2);
        add(1, 1, 3, 1, 0, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 1, 0, 0, 0, 0, 2);
        add(1, 1, 1, 1, 0, 0, 0, 0, 2);
        add(1, 1, 3, 1, 0, 0, 0, 0, 2);
        add(1, 1, 7, 2, 0, 0, 0, 0, 2);
        add(1, 0, 0, 3, 1, 0, 0, 0, 3);
        add(1, 0, 0, 4, 0, 1, 0, 0, 3);
        add(1, 0, 0, 0, 0, 0, 0, 0, 3);
        add(1, 0, 0, 1, 0, 0, 0, 0, 3);
        for (int k = 0; k < 7; k++) add(1, 0, 0, 1, 0, 0, 0, 0, 3);
        add(1, 1, 1, 1, 0, 0, 0, 0, 3);
        for (int k = 0; k < 7; k++) add(1, 0, 0, 1, 0, 0, 0, 0, 3);
        add(1, 1, 3, 1, 0, 0, 0, 0, 3);
        add(1, 1, 7, 2, 0, 0, 0, 0, 3);
        add(1, 0, 0, 3, 1, 0, 0, 0, 3);
        add(1, 0, 0, 4, 0, 1, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 3);
        b_hi = vecs.size();

        // C: 4-digit, 4-bit, two-try instance
        cur_sel = 1'b1;
        add(1, 0, 0,  1, 0, 0, 0, 0, 2);
        add(1, 1, 12, 1, 0, 0, 0, 0, 2);
        add(1, 1, 2,  1, 0, 0, 0, 0, 2);
        add(1, 1, 5,  1, 0, 0, 0, 0, 2);
        add(1, 1, 9,  2, 0, 0, 0, 0, 2);
        add(1, 0, 0,  3, 1, 0, 0, 0, 2);
        add(1, 0, 0,  4, 0, 1, 0, 0, 2);
        add(0, 0, 0,  0, 0, 0, 0, 0, 2);
        add(1, 0, 0,  1, 0, 0, 0, 0, 2);
        add(1, 1, 12, 1, 0, 0, 0, 0, 2);
        add(1, 1, 2,  1, 0, 0, 0, 0, 2);
        add(1, 1, 5,  1, 0, 0, 0, 0, 2);
        add(1, 1, 8,  2, 0, 0, 0, 0, 2);
        add(1, 0, 0,  1, 0, 0, 0, 0, 1);
        add(1, 1, 3,  1, 0, 0, 0, 0, 1);
        add(1, 1, 2,  1, 0, 0, 0, 0, 1);
        add(1, 1, 5,  1, 0, 0, 0, 0, 1);
        add(1, 1, 9,  2, 0, 0, 0, 0, 1);
        add(1, 0, 0,  5, 0, 0, 1, 0, 0);
        add(1, 0, 0,  6, 0, 0, 0, 1, 0);
        c_hi = vecs.size();

        step();
        step();
        check("reset_dut1", 1'b0, 0, 0, 0, 0, 0, 3);
        check("reset_dut2", 1'b1, 0, 0, 0, 0, 0, 2);
        @(negedge clk_2);
        reset = 1'b0;

        run(0, a_hi);
        #2 reset = 1'b1;
        #1 check("reset_locked", 1'b0, 0, 0, 0, 0, 0, 3);
        #1 reset = 1'b0;

        run(a_hi, b_hi);
        run(b_hi, c_hi);

        #2 reset = 1'b1;
        #1 check("reset_locked2", 1'b1, 0, 0, 0, 0, 0, 2);
        #1 reset = 1'b0;

        // Reset mid-ENTRY, then reset during the CASH cycle
        card1 = 1'b1;
        step();
        dv1 = 1'b1; digit1 = 3'd1;
        step();
        check("entry_before_reset", 1'b0, 1, 0, 0, 0, 0, 3);
        dv1 = 1'b0;
        #2 reset = 1'b1;
        #1 check("reset_mid_entry", 1'b0, 0, 0, 0, 0, 0, 3);
        #1 reset = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            dv1 = 1'b1; digit1 = good[i];
            step();
        end
        dv1 = 1'b0;
        check("check_before_cash", 1'b0, 2, 0, 0, 0, 0, 3);
        step();
        check("cash_before_reset", 1'b0, 3, 1, 0, 0, 0, 3);
        #2 reset = 1'b1;
        #1 check("reset_in_cash", 1'b0, 0, 0, 0, 0, 0, 3);
        #1 reset = 1'b0;
        card1 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
